// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : icache_ctrl
// Brief   : Direct-mapped read-only instruction cache, one 256-bit line refill per miss.
// Revision: 1.0
// ============================================================================
module icache_ctrl #(
    parameter int LINE_NUM = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             p1_req_i,
    input  logic [31:0]      p1_addr_i,
    output logic [31:0]      p1_data_o,
    output logic             p1_stall_o,
    input  logic             invalidate_i,
    output logic             mem_enable_o,
    output logic [31:0]      mem_addr_o,
    input  logic [255:0]     mem_data_i,
    input  logic             mem_ack_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 27 - IDX_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(LINE_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_INVAL = 2'd2
    } state_t;

    state_t              r_state;
    logic [LINE_NUM-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [LINE_NUM];
    logic [255:0]        r_data [LINE_NUM];
    logic                r_inval_pend;
    logic [IDX_W-1:0]    r_sweep;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [2:0]       w_off;
    logic             w_hit;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_fill;
    logic             w_unused;

    assign w_idx      = p1_addr_i[IDX_W+4:5];
    assign w_tag      = p1_addr_i[31:IDX_W+5];
    assign w_off      = p1_addr_i[4:2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // The refill target comes from the latched line address, not the live fetch address.
    assign w_fill_idx = mem_addr_o[IDX_W+4:5];
    assign w_fill_tag = mem_addr_o[31:IDX_W+5];
    assign w_fill     = (r_state == S_WAIT) && mem_ack_i;
    assign w_unused   = &{1'b0, p1_addr_i[1:0], mem_addr_o[4:0]};

    assign p1_data_o  = w_hit ? r_data[w_idx][{w_off, 5'b00000} +: 32] : 32'd0;
    assign p1_stall_o = (r_state != S_IDLE) || (p1_req_i && !w_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_inval_pend <= 1'b0;
            r_sweep      <= '0;
            mem_enable_o <= 1'b0;
            mem_addr_o   <= 32'd0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (invalidate_i || r_inval_pend) begin
                        r_state      <= S_INVAL;
                        r_inval_pend <= 1'b0;
                        r_sweep      <= '0;
                    end else if (p1_req_i && !w_hit) begin
                        r_state      <= S_WAIT;
                        mem_enable_o <= 1'b1;
                        mem_addr_o   <= {p1_addr_i[31:5], 5'b00000};
                        if (miss_cnt_o != C_CNT_MAX) begin
                            miss_cnt_o <= miss_cnt_o + 1'b1;
                        end
                    end else if (p1_req_i) begin
                        if (hit_cnt_o != C_CNT_MAX) begin
                            hit_cnt_o <= hit_cnt_o + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (invalidate_i) begin
                        r_inval_pend <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        mem_enable_o        <= 1'b0;
                        r_state             <= S_IDLE;
                    end
                end
                S_INVAL: begin
                    r_valid[r_sweep] <= 1'b0;
                    r_sweep          <= r_sweep + 1'b1;
                    if (r_sweep == C_LAST_IDX) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data and tags need no reset: the valid bits alone decide whether they are used.
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_data[w_fill_idx] <= mem_data_i;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire
